// File: rtl/led_pattern_pkg.sv
// Shared types and constants for the LED pattern engine.
// Holds the mode encoding, the command word field layout, the handshake states
// and the tick divisor helper used by led_pattern_gen and led_pwm.
package led_pattern_pkg;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_ON      = 2'd1,
        MODE_BLINK   = 2'd2,
        MODE_BREATHE = 2'd3
    } mode_e;

    // Command handshake: INIT is the single cycle after reset release.
    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_RUN  = 2'd1,
        ST_LOAD = 2'd2
    } state_e;

    localparam int MODE_LSB   = 0;
    localparam int MODE_W     = 2;
    localparam int DUTY_LSB   = 2;
    localparam int DUTY_W     = 8;
    localparam int PERIOD_LSB = 10;
    localparam int PERIOD_W   = 16;
    localparam int CMD_USED_W = PERIOD_LSB + PERIOD_W;

    // Clocks per pattern tick; the prescaler needs at least two states.
    function automatic int tick_div(input int clk_hz, input int tick_hz);
        int d;
        d = clk_hz / tick_hz;
        return (d < 2) ? 2 : d;
    endfunction

endpackage

// File: rtl/led_pwm.sv
// PWM generator: free-running frame counter compared against a brightness level.
// Latency: pwm_on follows level/en combinationally; with LED_PATTERN_GAMMA_EN the
// square-law stage adds one register. No backpressure.
// Ports: i_clk, i_rst_n (async, active-low), i_clr (restart frame), i_level, i_en, o_pwm_on.
module led_pwm
    import led_pattern_pkg::*;
#(
    parameter int PWM_BITS = 8
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_clr,
    input  logic [PWM_BITS-1:0] i_level,
    input  logic                i_en,
    output logic                o_pwm_on
);

    localparam logic [PWM_BITS-1:0] LVL_MAX = '1;

    logic [PWM_BITS-1:0] r_cnt;
    logic [PWM_BITS-1:0] w_level_eff;
    logic                w_on;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

`ifdef LED_PATTERN_GAMMA_EN
    logic [2*PWM_BITS-1:0] w_lvl_ext;
    logic [2*PWM_BITS-1:0] w_sq;
    logic                  w_unused_sq;
    logic                  r_pwm_on;

    assign w_lvl_ext   = {{PWM_BITS{1'b0}}, i_level};
    assign w_sq        = w_lvl_ext * w_lvl_ext;
    assign w_unused_sq = &{1'b0, w_sq[PWM_BITS-1:0]};
    // Full scale would otherwise map to MAX-1 and flicker once per frame.
    assign w_level_eff = (i_level == LVL_MAX) ? LVL_MAX : w_sq[2*PWM_BITS-1:PWM_BITS];
`else
    assign w_level_eff = i_level;
`endif

    // MAX is forced fully on; a plain compare would leave one dark clock per frame.
    assign w_on = i_en && ((w_level_eff == LVL_MAX) || (r_cnt < w_level_eff));

`ifdef LED_PATTERN_GAMMA_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pwm_on <= 1'b0;
        end else begin
            r_pwm_on <= w_on;
        end
    end
    assign o_pwm_on = r_pwm_on;
`else
    assign o_pwm_on = w_on;
`endif

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern engine for the loaned HPS LED pin: OFF / ON (PWM) / BLINK / BREATHE.
// Latency: accept -> LOAD -> new pattern; led_o is 1 register after pwm_on/phase
// (2 with LED_PATTERN_GAMMA_EN). Backpressure: cmd_ready_o drops for the LOAD cycle.
// Ports: clk_25m_i, rst_n_i (async, active-low), cmd_data_i/cmd_valid_i/cmd_ready_o,
// led_o/led_oe_o to loan-IO bit 9, mode_o and phase_o status.
module led_pattern_gen
    import led_pattern_pkg::*;
#(
    parameter int CLK_HZ   = 25000000,
    parameter int TICK_HZ  = 1000,
    parameter int PWM_BITS = 8
) (
    input  logic        clk_25m_i,
    input  logic        rst_n_i,
    input  logic [31:0] cmd_data_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    output logic        led_o,
    output logic        led_oe_o,
    output logic [1:0]  mode_o,
    output logic        phase_o
);

    localparam int                  DIV      = tick_div(CLK_HZ, TICK_HZ);
    localparam int                  PRE_W    = $clog2(DIV);
    localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(DIV - 1);
    localparam logic [PWM_BITS-1:0] LVL_MAX  = '1;
    localparam logic [PWM_BITS-1:0] LVL_ONE  = PWM_BITS'(1);

    state_e                  r_state;
    logic                    r_ready;
    logic                    r_oe;
    logic                    r_led;
    logic                    r_phase;
    mode_e                   r_mode;
    logic [DUTY_W-1:0]       r_duty;
    logic [PERIOD_W-1:0]     r_period;
    logic [CMD_USED_W-1:0]   r_cmd;
    logic [PRE_W-1:0]        r_presc;
    logic [PERIOD_W-1:0]     r_per_cnt;
    logic [PWM_BITS-1:0]     r_bright;

    logic                    w_accept;
    logic                    w_load;
    logic                    w_tick;
    logic [PERIOD_W-1:0]     w_period_m1;
    logic                    w_per_last;
    logic [PWM_BITS-1:0]     w_level;
    logic                    w_en;
    logic                    w_pwm_on;
    logic                    w_unused_cmd;

    assign w_unused_cmd = &{1'b0, cmd_data_i[31:CMD_USED_W]};

    assign w_accept    = cmd_valid_i && r_ready;
    assign w_load      = (r_state == ST_LOAD);
    assign w_tick      = (r_presc == PRE_LAST);
    // A period of 0 behaves as 1.
    assign w_period_m1 = (r_period == '0) ? '0 : (r_period - 16'd1);
    assign w_per_last  = (r_per_cnt == w_period_m1);
    assign w_level     = (r_mode == MODE_BREATHE) ? r_bright : PWM_BITS'(r_duty);
    assign w_en        = (r_mode == MODE_ON) || (r_mode == MODE_BREATHE) ||
                         ((r_mode == MODE_BLINK) && r_phase);

    led_pwm #(
        .PWM_BITS (PWM_BITS)
    ) u_pwm (
        .i_clk    (clk_25m_i),
        .i_rst_n  (rst_n_i),
        .i_clr    (w_load),
        .i_level  (w_level),
        .i_en     (w_en),
        .o_pwm_on (w_pwm_on)
    );

    always_ff @(posedge clk_25m_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state   <= ST_INIT;
            r_ready   <= 1'b0;
            r_oe      <= 1'b0;
            r_led     <= 1'b0;
            r_phase   <= 1'b0;
            r_mode    <= MODE_OFF;
            r_duty    <= '0;
            r_period  <= '0;
            r_cmd     <= '0;
            r_presc   <= '0;
            r_per_cnt <= '0;
            r_bright  <= '0;
        end else begin
            r_oe  <= 1'b1;
            r_led <= w_pwm_on;
            case (r_state)
                ST_INIT: begin
                    r_ready <= 1'b1;
                    r_state <= ST_RUN;
                end
                ST_LOAD: begin
                    // Any tick pending here is dropped: the new pattern starts clean.
                    r_mode    <= mode_e'(r_cmd[MODE_LSB +: MODE_W]);
                    r_duty    <= r_cmd[DUTY_LSB +: DUTY_W];
                    r_period  <= r_cmd[PERIOD_LSB +: PERIOD_W];
                    r_presc   <= '0;
                    r_per_cnt <= '0;
                    r_bright  <= '0;
                    r_phase   <= 1'b1;
                    r_ready   <= 1'b1;
                    r_state   <= ST_RUN;
                end
                ST_RUN: begin
                    if (w_accept) begin
                        // Counters freeze on the accept edge so a coincident tick is lost.
                        r_cmd   <= cmd_data_i[CMD_USED_W-1:0];
                        r_ready <= 1'b0;
                        r_state <= ST_LOAD;
                    end else begin
                        r_presc <= w_tick ? '0 : (r_presc + 1'b1);
                        if (w_tick && ((r_mode == MODE_BLINK) || (r_mode == MODE_BREATHE))) begin
                            if (w_per_last) begin
                                r_per_cnt <= '0;
                                if (r_mode == MODE_BLINK) begin
                                    r_phase <= ~r_phase;
                                end else if (r_phase) begin
                                    // Turn around on the step that reaches full scale.
                                    if (r_bright != LVL_MAX) r_bright <= r_bright + 1'b1;
                                    if (r_bright >= LVL_MAX - LVL_ONE) r_phase <= 1'b0;
                                end else begin
                                    if (r_bright != '0) r_bright <= r_bright - 1'b1;
                                    if (r_bright <= LVL_ONE) r_phase <= 1'b1;
                                end
                            end else begin
                                r_per_cnt <= r_per_cnt + 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    r_ready <= 1'b0;
                    r_state <= ST_INIT;
                end
            endcase
        end
    end

    assign cmd_ready_o = r_ready;
    assign led_o       = r_led;
    assign led_oe_o    = r_oe;
    assign mode_o      = r_mode;
    assign phase_o     = r_phase;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Scoreboard bench for led_pattern_gen: CLK_HZ=1000, TICK_HZ=100 (tick every 10 clocks).
// u_dut uses PWM_BITS=8, u_dut4 uses PWM_BITS=4 for the BREATHE sweep.
module tb_led_pattern_gen;

`ifdef LED_PATTERN_GAMMA_EN
    localparam int LAT   = 3;
    localparam bit GAMMA = 1'b1;
`else
    localparam int LAT   = 2;
    localparam bit GAMMA = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] cmd_data, cmd_data4;
    logic        cmd_valid, cmd_valid4;
    logic        ready, led, oe, phase;
    logic [1:0]  mode;
    logic        ready4, led4, oe4, phase4;
    logic [1:0]  mode4;

    always #5 clk = ~clk;

    led_pattern_gen #(.CLK_HZ(1000), .TICK_HZ(100), .PWM_BITS(8)) u_dut (
        .clk_25m_i(clk), .rst_n_i(rst_n), .cmd_data_i(cmd_data), .cmd_valid_i(cmd_valid),
        .cmd_ready_o(ready), .led_o(led), .led_oe_o(oe), .mode_o(mode), .phase_o(phase));

    led_pattern_gen #(.CLK_HZ(1000), .TICK_HZ(100), .PWM_BITS(4)) u_dut4 (
        .clk_25m_i(clk), .rst_n_i(rst_n), .cmd_data_i(cmd_data4), .cmd_valid_i(cmd_valid4),
        .cmd_ready_o(ready4), .led_o(led4), .led_oe_o(oe4), .mode_o(mode4), .phase_o(phase4));

    typedef struct {
        string name;
        int    sig;
        int    t0;
        int    t1;
        int    kind;   // 0: value held over [t0,t1); 1: count of ones over [t0,t1)
        int    exp;
        int    acc;
        bit    bad;
        int    bad_cyc;
        int    bad_val;
    } chk_t;

    chk_t sb[$];
    chk_t sb_keep[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int probe(input int s);
        case (s)
            0: return int'(led);
            1: return int'(oe);
            2: return int'(ready);
            3: return int'(mode);
            4: return int'(phase);
            5: return int'(u_dut.r_per_cnt);
            6: return int'(phase4);
            7: return int'(u_dut4.r_bright);
            default: return -1;
        endcase
    endfunction

    function automatic logic [31:0] mk(input int m, input int d, input int p);
        logic [1:0]  mm;
        logic [7:0]  dd;
        logic [15:0] pp;
        mm = m[1:0];
        dd = d[7:0];
        pp = p[15:0];
        return {6'd0, pp, dd, mm};
    endfunction

    function automatic int exp_high(input int duty);
        if (duty == 255) return 256;
        if (GAMMA) return (duty * duty) >> 8;
        return duty;
    endfunction

    task automatic push(input string nm, input int s, input int t0, input int t1,
                        input int kind, input int v);
        chk_t e;
        e.name = nm; e.sig = s; e.t0 = t0; e.t1 = t1; e.kind = kind; e.exp = v;
        e.acc = 0; e.bad = 1'b0; e.bad_cyc = 0; e.bad_val = 0;
        sb.push_back(e);
    endtask

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: samples every falling edge, retires entries at the end of their window.
    always @(negedge clk) begin
        int v;
        sb_keep = {};
        foreach (sb[i]) begin
            if (cyc >= sb[i].t0 && cyc < sb[i].t1) begin
                v = probe(sb[i].sig);
                if (sb[i].kind == 1) begin
                    if (v == 1) sb[i].acc = sb[i].acc + 1;
                end else if (v != sb[i].exp && !sb[i].bad) begin
                    sb[i].bad = 1'b1;
                    sb[i].bad_cyc = cyc;
                    sb[i].bad_val = v;
                end
            end
            if (cyc >= sb[i].t1 - 1) begin
                n_checks++;
                if (sb[i].kind == 1 && sb[i].acc != sb[i].exp) begin
                    n_fail++;
                    $display("FAIL %s: count %0d, expected %0d", sb[i].name, sb[i].acc, sb[i].exp);
                end else if (sb[i].kind == 0 && sb[i].bad) begin
                    n_fail++;
                    $display("FAIL %s: cycle %0d got %0d, expected %0d",
                             sb[i].name, sb[i].bad_cyc, sb[i].bad_val, sb[i].exp);
                end
            end else begin
                sb_keep.push_back(sb[i]);
            end
        end
        sb = sb_keep;
    end

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Present a command (optionally at a given cycle); acc = cycle number of the accept edge.
    task automatic send(input bit which, input logic [31:0] d, input int at_cyc,
                        input bit hold, output int acc);
        int n;
        acc = -1;
        @(negedge clk);
        while (cyc < at_cyc) @(negedge clk);
        #1;
        if (which) begin cmd_data4 = d; cmd_valid4 = 1'b1; end
        else       begin cmd_data  = d; cmd_valid  = 1'b1; end
        n = 0;
        while (!(which ? ready4 : ready) && n < 50) begin
            @(negedge clk); #1; n++;
        end
        if (!(which ? ready4 : ready)) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: ready never rose, expected 1");
            cmd_valid = 1'b0;
            cmd_valid4 = 1'b0;
        end else begin
            @(posedge clk); #1;
            acc = cyc;
            if (!hold) begin cmd_valid = 1'b0; cmd_valid4 = 1'b0; end
        end
    endtask

    initial begin
        int a, a2, b, c, r, h, t, n;
        int duties[3];
        duties = '{64, 128, 0};
        cmd_valid = 1'b0; cmd_data = '0; cmd_valid4 = 1'b0; cmd_data4 = '0;
        #1 rst_n = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_led", int'(led), 0);
        check("rst_oe", int'(oe), 0);
        check("rst_ready", int'(ready), 0);
        check("rst_mode", int'(mode), 0);
        check("rst_phase", int'(phase), 0);
        rst_n = 1'b1;
        r = cyc + 1;
        push("post_rst_oe", 1, r, r + 5, 0, 1);
        push("post_rst_ready", 2, r, r + 5, 0, 1);
        push("post_rst_led", 0, r, r + 5, 0, 0);
        push("post_rst_mode", 3, r, r + 5, 0, 0);
        wait_until(r + 6);

        // BREATHE, period 1, 4-bit brightness
        send(1'b1, mk(3, 0, 1), -1, 1'b0, a);
        push("br_phase_up", 6, a + 1, a + 151, 0, 1);
        push("br_phase_down", 6, a + 151, a + 301, 0, 0);
        push("br_phase_up2", 6, a + 301, a + 321, 0, 1);
        for (int j = 0; j < 16; j++) push("br_bright_up", 7, a + 5 + 10 * j, a + 6 + 10 * j, 0, j);
        for (int j = 1; j < 16; j++) push("br_bright_dn", 7, a + 155 + 10 * j, a + 156 + 10 * j, 0, 15 - j);
        push("br_bright_rise", 7, a + 315, a + 316, 0, 1);
        push("off_led_idle", 0, a, a + 320, 1, 0);
        wait_until(a + 322);

        // ON, full duty
        send(1'b0, mk(1, 255, 0), -1, 1'b0, a);
        push("load_ready_low", 2, a, a + 1, 0, 0);
        push("load_ready_back", 2, a + 1, a + 4, 0, 1);
        push("load_mode_old", 3, a, a + 1, 0, 0);
        push("on_mode", 3, a + 1, a + 300, 0, 1);
        push("on255_latency", 0, a, a + LAT, 0, 0);
        push("on255_high", 0, a + LAT, a + LAT + 300, 0, 1);
        wait_until(a + LAT + 301);

        // ON, partial duties
        foreach (duties[k]) begin
            send(1'b0, mk(1, duties[k], 0), -1, 1'b0, a);
            h = exp_high(duties[k]);
            push("on_frame_cnt", 0, a + LAT, a + LAT + 256, 1, h);
            push("on_frame_cnt2", 0, a + LAT + 256, a + LAT + 512, 1, h);
            if (h > 0) push("on_frame_high", 0, a + LAT, a + LAT + h, 0, 1);
            push("on_frame_low", 0, a + LAT + h, a + LAT + 256, 0, 0);
            wait_until(a + LAT + 513);
        end

        // BLINK, period 3 ticks
        send(1'b0, mk(2, 255, 3), -1, 1'b0, a);
        push("blink_mode", 3, a + 1, a + 90, 0, 2);
        push("blink_ph1", 4, a + 1, a + 31, 0, 1);
        push("blink_ph0", 4, a + 31, a + 61, 0, 0);
        push("blink_ph1b", 4, a + 61, a + 91, 0, 1);
        push("blink_led1", 0, a + LAT, a + LAT + 30, 0, 1);
        push("blink_led0", 0, a + LAT + 30, a + LAT + 60, 0, 0);
        push("blink_led1b", 0, a + LAT + 60, a + LAT + 90, 0, 1);
        wait_until(a + LAT + 91);

        // BLINK, period 0 -> 10-clock half periods, then a command on a tick cycle
        send(1'b0, mk(2, 255, 0), -1, 1'b0, a);
        push("p0_ph1", 4, a + 1, a + 11, 0, 1);
        push("p0_ph0", 4, a + 11, a + 21, 0, 0);
        push("p0_ph1b", 4, a + 21, a + 31, 0, 1);
        t = a + 30;
        send(1'b0, mk(2, 255, 3), t, 1'b0, a2);
        check("coll_accept_cyc", a2, t + 1);
        push("coll_ready_low", 2, a2, a2 + 1, 0, 0);
        push("coll_ready_back", 2, a2 + 1, a2 + 5, 0, 1);
        push("coll_phase_hold", 4, a2, a2 + 31, 0, 1);
        push("coll_phase_fall", 4, a2 + 31, a2 + 41, 0, 0);
        push("coll_per_cnt", 5, a2 + 1, a2 + 11, 0, 0);
        wait_until(a2 + 42);

        // Valid held for three cycles -> re-accepted only after ready returns
        send(1'b0, mk(2, 255, 3), -1, 1'b1, a);
        push("hold_ready0", 2, a, a + 1, 0, 0);
        push("hold_ready1", 2, a + 1, a + 2, 0, 1);
        push("hold_ready2", 2, a + 2, a + 3, 0, 0);
        push("hold_ready3", 2, a + 3, a + 7, 0, 1);
        push("hold_phase1", 4, a + 3, a + 33, 0, 1);
        push("hold_phase0", 4, a + 33, a + 43, 0, 0);
        repeat (2) @(posedge clk);
        #1 cmd_valid = 1'b0;
        wait_until(a + 44);

        // Reset asserted mid-BLINK during a LOAD: outputs drop at once, command is lost
        send(1'b0, mk(2, 255, 3), -1, 1'b0, b);
        send(1'b0, mk(1, 128, 0), b + 10, 1'b0, c);
        check("pre_rst_led", int'(led), 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_led", int'(led), 0);
        check("async_rst_oe", int'(oe), 0);
        check("async_rst_ready", int'(ready), 0);
        check("async_rst_mode", int'(mode), 0);
        check("async_rst_phase", int'(phase), 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        r = cyc + 1;
        push("lost_cmd_mode", 3, r, r + 20, 0, 0);
        push("lost_cmd_led", 0, r, r + 20, 1, 0);
        push("rerst_ready", 2, r, r + 5, 0, 1);
        wait_until(r + 21);

        n = 0;
        while (sb.size() != 0 && n < 200) begin @(negedge clk); n++; end
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d entries pending, expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/led_pattern_gen.md
Name: led_pattern_gen

Overview:
- Pattern engine between the HPS LED PIO export and the loaned HPS pin (LOANIO09) that drives the board LED.
- Takes a 32-bit command word from the PIO and produces the LED data and output-enable bits for the loan-IO vectors.
- Modes: OFF, ON (PWM brightness), BLINK, BREATHE. Runs entirely in the 25 MHz fabric clock domain.

Parameters:
- CLK_HZ, 25000000, fabric clock frequency.
- TICK_HZ, 1000, pattern time base; one tick = 1 ms by default.
- PWM_BITS, 8, brightness resolution; PWM frame = 2^PWM_BITS clocks.

Ports:
- clk_25m_i  in  1  fabric clock
- rst_n_i  in  1  reset; asynchronous, active-low
- cmd_data_i  in  32  command word:
  - [1:0] mode: 0 OFF, 1 ON, 2 BLINK, 3 BREATHE
  - [9:2] duty
  - [25:10] period in ticks
  - [31:26] ignored
- cmd_valid_i  in  1  command strobe
- cmd_ready_o  out  1  engine can accept a command
- led_o  out  1  to hps_loan_io_out[9]
- led_oe_o  out  1  to hps_loan_io_oe[9]
- mode_o  out  2  active mode
- phase_o  out  1  BLINK on-phase / BREATHE rising-phase flag

Behaviour:
- Reset values (asynchronous assertion): led_o=0, led_oe_o=0, cmd_ready_o=0, mode_o=OFF, phase_o=0, all counters 0.
- First clock after reset release: led_oe_o=1 (then constant), cmd_ready_o=1.
- Handshake:
  - A command is accepted on a rising edge with cmd_valid_i && cmd_ready_o.
  - Next cycle is LOAD: cmd_ready_o=0. Mode, duty and period registers update; tick prescaler, PWM counter and period counter clear; phase_o=1.
  - cmd_ready_o returns to 1 the cycle after LOAD.
  - Valid held through LOAD is not re-accepted until ready is high again. A held valid is then accepted again, re-applying the same command.
- Tick: prescaler counts 0..CLK_HZ/TICK_HZ-1 and pulses tick for one cycle at terminal count. CLK_HZ/TICK_HZ must be >=2.
- PWM: free-running counter pwm_cnt of PWM_BITS.
  - pwm_on = (pwm_cnt < level).
  - level = 2^PWM_BITS-1 forces pwm_on=1 permanently.
  - level = 0 forces 0.
- Period value 0 is treated as 1.
- Modes, each with its level source:
  - OFF: led_o=0.
  - ON: level=duty; led_o=pwm_on.
  - BLINK: per_cnt counts ticks. At per_cnt==period-1, phase_o toggles and per_cnt clears. led_o = phase_o ? pwm_on : 0.
  - BREATHE: bright register steps once per `period` ticks. It moves +1 while phase_o=1 and -1 while phase_o=0. It reverses at 2^PWM_BITS-1 and at 0; no overshoot and no wrap. level=bright; duty is ignored.
- led_o is registered: one-cycle latency from pwm_on / phase.
- Simultaneous events:
  - Command LOAD coinciding with a tick or period terminal count: LOAD wins, that tick is discarded.
  - New mode takes effect in LOAD with counters cleared.
- Reset mid-pattern: outputs go to reset values immediately, and the pending command is lost.
- mode_o reflects the register loaded in LOAD.

Optional Feature:
- Macro LED_PATTERN_GAMMA_EN.
- Defined: level passes through square-law correction, level_eff = (level*level) >> PWM_BITS. The exception is level = 2^PWM_BITS-1, which stays full-on. This adds one pipeline register, so led_o latency becomes 2 cycles.
- Undefined: linear level, 1-cycle latency.

Decomposition:
- Package led_pattern_pkg:
  - mode enum (MODE_OFF, MODE_ON, MODE_BLINK, MODE_BREATHE)
  - command field LSB/width constants (MODE_LSB=0, DUTY_LSB=2, PERIOD_LSB=10, PERIOD_W=16)
  - function for tick divisor
- Sub-module led_pwm: PWM counter, compare and optional gamma stage. Parameter PWM_BITS; inputs level and en; output pwm_on.

Test Plan (CLK_HZ=1000, TICK_HZ=100 → tick every 10 clocks, PWM_BITS=8 unless noted):
- Reset release → led_oe_o=1 and cmd_ready_o=1 on first edge, led_o=0, mode_o=0. Assert rst_n_i mid-BLINK → led_o=0 without a clock edge.
- Command ON duty=255 → led_o=1 continuously from 2 cycles after accept. Duty=64 → exactly 64 high clocks per 256-clock frame. Duty=0 → led_o never 1.
- Command BLINK duty=255 period=3 → led_o high 30 clocks, low 30 clocks, repeating. phase_o toggles every 30 clocks. Period=0 → 10-clock half-periods.
- Command BREATHE period=1, PWM_BITS=4 → bright climbs 0..15 over 15 ticks, phase_o falls, descends to 0, then phase_o rises. No value outside 0..15.
- Assert cmd_valid_i on the cycle a tick fires in BLINK → cmd_ready_o=0 for exactly one cycle, per_cnt=0, phase_o=1, no toggle from the discarded tick. Hold valid for 3 cycles → second acceptance only after ready re-asserts.
- With LED_PATTERN_GAMMA_EN, ON duty=128 → 64 high clocks/frame, latency 3 cycles from accept. Duty=255 → constant high.
